// File: rtl/led_pio_arbiter_if.sv
// Avalon-MM link between the LED arbiter (master) and the LEDR PIO (slave).
// Zero-wait-state register port; readdata is combinational from the slave.
interface led_pio_arbiter_if;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [1:0]  avm_address;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_chipselect, avm_write_n, avm_address, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_chipselect, avm_write_n, avm_address, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/led_pio_arbiter.sv
// Round-robin sharing of the LEDR PIO: write, read back, ack, then hold HOLD_CYCLES.
// Request seen in IDLE at t: write at t+1, ack at t+3; requesters wait by holding req high.
module led_pio_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 5_000_000,
  parameter int HOLD_W      = 23
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [2:0]                owner,
  output logic                      busy,
  output logic                      err,
  input  logic                      err_clr,
  led_pio_arbiter_if.master         avm
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, HOLD} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] pat, grant_dat;
  logic [2:0]        grant_idx, hi_idx, lo_idx;
  logic              hi_vld, lo_vld;
  logic              mism;
  logic [HOLD_W-1:0] hold_cnt;
  logic              unused_readdata_hi;

  assign unused_readdata_hi = ^avm.avm_readdata[31:DATA_W];

  // Descending scan leaves the lowest index set: hi_* is the first requester
  // above owner, lo_* the lowest overall (the wrap-around candidate).
  always_comb begin
    hi_vld    = 1'b0;
    lo_vld    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    grant_dat = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(owner)) begin
          hi_vld = 1'b1;
          hi_idx = 3'(i);
        end
        lo_vld = 1'b1;
        lo_idx = 3'(i);
      end
    end
    grant_idx = hi_vld ? hi_idx : lo_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 3'(i)) grant_dat = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    busy               = (state != IDLE);
    ack                = '0;
    avm.avm_chipselect = 1'b0;
    avm.avm_write_n    = 1'b1;
    avm.avm_address    = 2'd0;
    avm.avm_writedata  = '0;
    unique case (state)
      IDLE: begin
        if (lo_vld) state_nxt = WRITE;
      end
      WRITE: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_writedata  = 32'(pat);
        state_nxt          = READ;
      end
      READ: begin
        avm.avm_chipselect = 1'b1;
        state_nxt          = CHECK;
      end
      CHECK: begin
        for (int i = 0; i < NUM_REQ; i++) ack[i] = (owner == 3'(i));
        state_nxt = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (hold_cnt == HOLD_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 3'(NUM_REQ - 1);
      pat      <= '0;
      mism     <= 1'b0;
      err      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (state == IDLE && lo_vld) begin
        owner <= grant_idx;
        pat   <= grant_dat;
      end
      if (state == READ) mism <= (avm.avm_readdata[DATA_W-1:0] != pat);
      // A fresh mismatch outranks a simultaneous clear.
      if (state == CHECK && mism) err <= 1'b1;
      else if (err_clr)           err <= 1'b0;
      if (state == CHECK)     hold_cnt <= HOLD_LOAD;
      else if (state == HOLD) hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Directed bench for led_pio_arbiter with a PIO slave model and a transaction scoreboard.
// Expected writes/acks are queued at stimulus time and matched against logged bus activity.
module tb_led_pio_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int HOLD    = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        ack;
  logic [2:0]                owner;
  logic                      busy, err;
  logic                      err_clr = 1'b0;
  logic                      bad_rd = 1'b0;
  logic [7:0]                pio_reg = 8'h00;
  int                        cyc = 0;
  int                        checks = 0;
  int                        failures = 0;

  led_pio_arbiter_if avm_bus ();

  led_pio_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .HOLD_W(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .owner(owner), .busy(busy), .err(err), .err_clr(err_clr), .avm(avm_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave: latches on a write strobe, readback optionally corrupted to zero.
  always @(posedge clk)
    if (avm_bus.avm_chipselect && !avm_bus.avm_write_n && avm_bus.avm_address == 2'd0)
      pio_reg <= avm_bus.avm_writedata[7:0];
  assign avm_bus.avm_readdata = bad_rd ? 32'h0 : {24'h0, pio_reg};

  typedef struct { int wr_cyc; int ack_cyc; logic [1:0] ack_v; logic [2:0] own; logic [31:0] wd; } exp_t;
  typedef struct { int cyc; logic [31:0] wd; logic [1:0] addr; } wr_t;
  typedef struct { int cyc; logic [1:0] ack_v; logic [2:0] own; } ack_t;
  exp_t exp_q[$];
  wr_t  wr_log[$];
  ack_t ack_log[$];

  always @(negedge clk) begin
    if (avm_bus.avm_chipselect === 1'b1 && avm_bus.avm_write_n === 1'b0)
      wr_log.push_back('{cyc, avm_bus.avm_writedata, avm_bus.avm_address});
    if (|ack) ack_log.push_back('{cyc, ack, owner});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    check("reset_outputs", 64'({busy, ack, owner, err}), 64'({1'b0, 2'b00, 3'd1, 1'b0}));
    check("reset_bus", 64'({avm_bus.avm_chipselect, avm_bus.avm_write_n, avm_bus.avm_address, avm_bus.avm_writedata}),
          64'({1'b0, 1'b1, 2'd0, 32'd0}));
    reset = 1'b0;
    wr_log.delete();
    ack_log.delete();
    exp_q.delete();
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (ack_log.size() < n && k < budget) begin step(); k++; end
    check({tag, "_ack_wait"}, 64'(ack_log.size() >= n), 64'(1));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy && k < budget) begin step(); k++; end
    check({tag, "_idle_wait"}, 64'(busy), 64'(0));
  endtask

  task automatic score(input string tag);
    exp_t e;
    wr_t  w;
    ack_t a;
    e = exp_q.pop_front();
    check({tag, "_wr_seen"}, 64'(wr_log.size() != 0), 64'(1));
    if (wr_log.size() != 0) begin
      w = wr_log.pop_front();
      check({tag, "_wr_cyc"}, 64'(w.cyc), 64'(e.wr_cyc));
      check({tag, "_wdata"}, 64'(w.wd), 64'(e.wd));
      check({tag, "_addr"}, 64'(w.addr), 64'(0));
    end
    check({tag, "_ack_seen"}, 64'(ack_log.size() != 0), 64'(1));
    if (ack_log.size() != 0) begin
      a = ack_log.pop_front();
      check({tag, "_ack_cyc"}, 64'(a.cyc), 64'(e.ack_cyc));
      check({tag, "_ack_vec"}, 64'(a.ack_v), 64'(e.ack_v));
      check({tag, "_owner"}, 64'(a.own), 64'(e.own));
    end
  endtask

  initial begin
    int c;
    do_reset();

    // 1: single request from requester 0
    c = cyc;
    req = 2'b01; req_data = 16'h00A5;
    exp_q.push_back('{c + 1, c + 3, 2'b01, 3'd0, 32'h000000A5});
    step(); req = 2'b00;
    wait_acks(1, 20, "t1");
    check("t1_err", 64'(err), 64'(0));
    check("t1_owner", 64'(owner), 64'(0));
    wait_idle(20, "t1");
    score("t1");

    // 2: both held, alternating grants 8 cycles apart
    do_reset();
    c = cyc;
    req = 2'b11; req_data = {8'hF0, 8'h0F};
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{c + 1 + 8*k, c + 3 + 8*k, (k % 2 == 0) ? 2'b01 : 2'b10,
                        (k % 2 == 0) ? 3'd0 : 3'd1, (k % 2 == 0) ? 32'h0F : 32'hF0});
    wait_acks(4, 60, "t2");
    req = 2'b00;
    wait_idle(20, "t2");
    for (int k = 0; k < 4; k++) score($sformatf("t2_%0d", k));
    check("t2_extra_wr", 64'(wr_log.size()), 64'(0));

    // 3: readback mismatch sets sticky err, err_clr clears it
    bad_rd = 1'b1;
    c = cyc;
    req = 2'b01; req_data = 16'h003C;
    exp_q.push_back('{c + 1, c + 3, 2'b01, 3'd0, 32'h3C});
    step(); req = 2'b00;
    wait_acks(1, 20, "t3");
    check("t3_err_set", 64'(err), 64'(1));
    step(); step(); step();
    check("t3_err_sticky", 64'(err), 64'(1));
    bad_rd = 1'b0;
    wait_idle(20, "t3");
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("t3_err_clr", 64'(err), 64'(0));
    check("t3_pio", 64'(pio_reg), 64'(8'h3C));
    score("t3");

    // 4: mismatch and err_clr in the CHECK cycle: set wins
    bad_rd = 1'b1;
    c = cyc;
    req = 2'b01; req_data = 16'h0066;
    exp_q.push_back('{c + 1, c + 3, 2'b01, 3'd0, 32'h66});
    step(); req = 2'b00;
    step(); step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("t4_set_wins", 64'(err), 64'(1));
    bad_rd = 1'b0;
    wait_idle(20, "t4");
    score("t4");

    // 5: reset during READ aborts without ack; PIO keeps value
    do_reset();
    c = cyc;
    req = 2'b01; req_data = 16'h005A;
    step(); req = 2'b00;
    step();
    reset = 1'b1; step();
    check("t5_outputs", 64'({busy, ack, owner, avm_bus.avm_chipselect, avm_bus.avm_write_n}),
          64'({1'b0, 2'b00, 3'd1, 1'b0, 1'b1}));
    reset = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("t5_no_ack", 64'(ack_log.size()), 64'(0));
    check("t5_one_wr", 64'(wr_log.size()), 64'(1));
    if (wr_log.size() != 0) check("t5_wr_cyc", 64'(wr_log[0].cyc), 64'(c + 1));
    check("t5_pio", 64'(pio_reg), 64'(8'h5A));
    wr_log.delete();

    // 6: req[1] raised and dropped inside HOLD is forfeited
    do_reset();
    c = cyc;
    req = 2'b01; req_data = 16'h0011;
    exp_q.push_back('{c + 1, c + 3, 2'b01, 3'd0, 32'h11});
    step(); req = 2'b00;
    step(); step(); step();
    req = 2'b10; req_data = 16'h2200;
    step(); step();
    req = 2'b00;
    step();
    check("t6_busy_last_hold", 64'(busy), 64'(1));
    step();
    check("t6_busy_fell", 64'(busy), 64'(0));
    for (int k = 0; k < 6; k++) step();
    score("t6");
    check("t6_no_wr", 64'(wr_log.size()), 64'(0));
    check("t6_no_ack", 64'(ack_log.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
